// File: rtl/rob_gram_sdp_vt.sv
// rob_gram_sdp_vt: simple-dual-port ROB RAM with per-entry valid bits,
// byte-enable writes, 1/2-cycle read latency and defined same-address collisions.
// Ports:
//   clk, rst_n (async, active low)
//   we/waddr/wbe/din           write port
//   re/raddr                   read port
//   flush                      clears every valid bit
//   dout/rvalid/dout_valid     read response
//   count                      number of valid entries
module rob_gram_sdp_vt #(
    parameter int ADDR_W        = 4,
    parameter int DATA_W        = 32,
    parameter int RD_LAT        = 1,
    parameter int RW_MODE       = 1,
    parameter int CLEAR_ON_READ = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic [DATA_W-1:0]   din,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    input  logic                flush,
    output logic [DATA_W-1:0]   dout,
    output logic                rvalid,
    output logic                dout_valid,
    output logic [ADDR_W:0]     count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic              coll;
    logic              wr_set;
    logic              rd_clr;
    logic [DATA_W-1:0] rd_old, rd_new, rd_data;
    logic              rd_vld;

    logic              s1_vld_q;
    logic [DATA_W-1:0] s1_data_q;
    logic              s1_dv_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (wbe[b]) begin
                    mem_q[waddr][8*b +: 8] <= din[8*b +: 8];
                end
            end
        end
    end

    assign coll = we && re && (waddr == raddr);

    // Bypass view of the entry as it will look after this edge's write.
    always_comb begin
        rd_old = mem_q[raddr];
        rd_new = rd_old;
        for (int b = 0; b < NB; b++) begin
            if (wbe[b]) begin
                rd_new[8*b +: 8] = din[8*b +: 8];
            end
        end
    end

    assign rd_data = (coll && RW_MODE == 1) ? rd_new : rd_old;
    assign rd_vld  = (coll && RW_MODE == 1) ? 1'b1 : valid_q[raddr];

    // Ordering on one edge: flush, then read-clear, then write (write wins).
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else if (re && CLEAR_ON_READ != 0) begin
            valid_d[raddr] = 1'b0;
        end
        if (we) begin
            valid_d[waddr] = 1'b1;
        end
    end

    assign wr_set = we && !valid_q[waddr];
    assign rd_clr = (CLEAR_ON_READ != 0) && re && valid_q[raddr] && !coll;

    always_comb begin
        if (flush) begin
            count_d = {{ADDR_W{1'b0}}, we};
        end else begin
            count_d = count_q
                    + {{ADDR_W{1'b0}}, wr_set}
                    - {{ADDR_W{1'b0}}, rd_clr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // First read stage; data fields only load on a request so they hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s1_dv_q   <= 1'b0;
        end else begin
            s1_vld_q <= re;
            if (re) begin
                s1_data_q <= rd_data;
                s1_dv_q   <= rd_vld;
            end
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        assign rvalid     = s1_vld_q;
        assign dout       = s1_data_q;
        assign dout_valid = s1_dv_q;
    end else if (RD_LAT == 2) begin : g_lat2
        logic              s2_vld_q;
        logic [DATA_W-1:0] s2_data_q;
        logic              s2_dv_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_vld_q  <= 1'b0;
                s2_data_q <= '0;
                s2_dv_q   <= 1'b0;
            end else begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    s2_data_q <= s1_data_q;
                    s2_dv_q   <= s1_dv_q;
                end
            end
        end

        assign rvalid     = s2_vld_q;
        assign dout       = s2_data_q;
        assign dout_valid = s2_dv_q;
    end else begin : g_bad_lat
        $error("rob_gram_sdp_vt: RD_LAT must be 1 or 2");
    end

    assign count = count_q;

endmodule

// File: tb/tb_rob_gram_sdp_vt.sv
// tb_rob_gram_sdp_vt: scoreboard bench for rob_gram_sdp_vt.
// Two instances share stimulus: defaults, and RD_LAT=2 / RW_MODE=0.
module tb_rob_gram_sdp_vt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we, re, flush;
    logic [3:0]  waddr, raddr, wbe;
    logic [31:0] din;

    logic [31:0] dout_a, dout_b;
    logic        rvalid_a, rvalid_b;
    logic        dv_a, dv_b;
    logic [4:0]  count_a, count_b;

    always #5 clk = ~clk;

    rob_gram_sdp_vt u_a (
        .clk(clk), .rst_n(rst_n),
        .we(we), .waddr(waddr), .wbe(wbe), .din(din),
        .re(re), .raddr(raddr), .flush(flush),
        .dout(dout_a), .rvalid(rvalid_a),
        .dout_valid(dv_a), .count(count_a)
    );

    rob_gram_sdp_vt #(.RD_LAT(2), .RW_MODE(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .we(we), .waddr(waddr), .wbe(wbe), .din(din),
        .re(re), .raddr(raddr), .flush(flush),
        .dout(dout_b), .rvalid(rvalid_b),
        .dout_valid(dv_b), .count(count_b)
    );

    typedef struct {
        int          due;
        logic [31:0] d;
        logic        v;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] mem_m [16];
    logic [15:0] val_m;
    int          cnt_nx;
    logic [4:0]  cnt_m;
    int          edge_n = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [31:0] hold_da, hold_db;
    logic        hold_va, hold_vb;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_m <= '0;
        else        cnt_m <= 5'(cnt_nx);
    end

    task automatic chk(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    // Drive one cycle, push expected responses, update the model.
    task automatic cyc(input logic w, input logic [3:0] wa,
                       input logic [3:0] be, input logic [31:0] d,
                       input logic r, input logic [3:0] ra,
                       input logic f);
        logic [31:0] old, nw;
        logic        coll;
        exp_t        e;
        we = w; waddr = wa; wbe = be; din = d;
        re = r; raddr = ra; flush = f;
        old = mem_m[ra];
        nw  = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) nw[8*b +: 8] = d[8*b +: 8];
        coll = w && r && (wa == ra);
        if (r) begin
            e.due = edge_n + 1;
            e.d   = coll ? nw : old;
            e.v   = coll ? 1'b1 : val_m[ra];
            qa.push_back(e);
            e.due = edge_n + 2;
            e.d   = old;
            e.v   = val_m[ra];
            qb.push_back(e);
        end
        if (w)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_m[wa][8*b +: 8] = d[8*b +: 8];
        if (f)      val_m = '0;
        else if (r) val_m[ra] = 1'b0;
        if (w)      val_m[wa] = 1'b1;
        cnt_nx = $countones(val_m);
        @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0; flush = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cyc(1'b1, a, 4'hF, d, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, a, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (qa.size() != 0 && qa[0].due == edge_n) begin
                chk("rvalid_a", 32'(rvalid_a), 32'd1);
                chk("dout_a", dout_a, qa[0].d);
                chk("dv_a", 32'(dv_a), 32'(qa[0].v));
                hold_da = qa[0].d;
                hold_va = qa[0].v;
                void'(qa.pop_front());
            end else begin
                chk("idle_rvalid_a", 32'(rvalid_a), 32'd0);
                chk("hold_dout_a", dout_a, hold_da);
                chk("hold_dv_a", 32'(dv_a), 32'(hold_va));
            end
            if (qb.size() != 0 && qb[0].due == edge_n) begin
                chk("rvalid_b", 32'(rvalid_b), 32'd1);
                chk("dout_b", dout_b, qb[0].d);
                chk("dv_b", 32'(dv_b), 32'(qb[0].v));
                hold_db = qb[0].d;
                hold_vb = qb[0].v;
                void'(qb.pop_front());
            end else begin
                chk("idle_rvalid_b", 32'(rvalid_b), 32'd0);
                chk("hold_dout_b", dout_b, hold_db);
                chk("hold_dv_b", 32'(dv_b), 32'(hold_vb));
            end
            chk("count_a", 32'(count_a), 32'(cnt_m));
            chk("count_b", 32'(count_b), 32'(cnt_m));
        end
    end

    initial begin
        we = 1'b0; re = 1'b0; flush = 1'b0;
        waddr = '0; raddr = '0; wbe = '0; din = '0;
        val_m = '0; cnt_nx = 0;
        hold_da = '0; hold_db = '0;
        hold_va = 1'b0; hold_vb = 1'b0;
        for (int i = 0; i < 16; i++) mem_m[i] = '0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout_a", dout_a, 32'h0);
        chk("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("rst_dv_a", 32'(dv_a), 32'd0);
        chk("rst_count_a", 32'(count_a), 32'd0);
        chk("rst_dout_b", dout_b, 32'h0);
        chk("rst_rvalid_b", 32'(rvalid_b), 32'd0);
        chk("rst_count_b", 32'(count_b), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // T1: fill, then drain in order
        for (int i = 0; i < 16; i++) wr(4'(i), 32'hCAFE_0000 + 32'(i));
        chk("t1_full_a", 32'(count_a), 32'd16);
        chk("t1_full_b", 32'(count_b), 32'd16);
        for (int i = 0; i < 16; i++) rd(4'(i));
        idle(3);
        chk("t1_empty_a", 32'(count_a), 32'd0);
        for (int i = 0; i < 16; i++) wr(4'(i), 32'hCAFE_0000 + 32'(i));

        // T2: back-to-back reads
        rd(4'd3); rd(4'd4); rd(4'd5);
        idle(3);

        // T3: partial byte write
        cyc(1'b1, 4'd7, 4'b0011, 32'h1234_5678, 1'b0, 4'd0, 1'b0);
        rd(4'd7);
        idle(3);

        // T4: same-address collision, then re-read
        cyc(1'b1, 4'd2, 4'hF, 32'hDEAD_BEEF, 1'b1, 4'd2, 1'b0);
        idle(2);
        rd(4'd2);
        idle(3);

        // T5: flush with a simultaneous write
        cyc(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 8; i++) wr(4'(i), 32'hCAFE_0000 + 32'(i));
        chk("t5_eight", 32'(count_a), 32'd8);
        cyc(1'b1, 4'd9, 4'hF, 32'h9999_0009, 1'b0, 4'd0, 1'b1);
        chk("t5_one_a", 32'(count_a), 32'd1);
        chk("t5_one_b", 32'(count_b), 32'd1);
        rd(4'd0); rd(4'd9);
        idle(3);

        // wbe=0 write still marks the entry valid
        cyc(1'b1, 4'd10, 4'h0, 32'hFFFF_FFFF, 1'b0, 4'd0, 1'b0);
        rd(4'd10);
        idle(3);

        // T6: async reset while reads are in flight
        wr(4'd1, 32'hB00B_0001);
        rd(4'd1);
        #2;
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        val_m = '0;
        cnt_nx = 0;
        hold_da = '0; hold_db = '0;
        hold_va = 1'b0; hold_vb = 1'b0;
        #1;
        chk("t6_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("t6_dout_a", dout_a, 32'h0);
        chk("t6_count_a", 32'(count_a), 32'd0);
        chk("t6_rvalid_b", 32'(rvalid_b), 32'd0);
        chk("t6_dout_b", dout_b, 32'h0);
        chk("t6_count_b", 32'(count_b), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        rd(4'd1);
        idle(4);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
